// File: rtl/cacheline_adaptor.sv
// Line-to-burst adaptor: splits one cache-line read/write into BEATS memory beats.
// Optional per-direction completion counters behind CACHELINE_ADAPTOR_PERF_EN.
module cacheline_adaptor #(
  parameter int LINE_W   = 256,
  parameter int BURST_W  = 64,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
`ifdef CACHELINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]        rd_count_o,
  output logic [31:0]        wr_count_o
`endif
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    beat_reg;
  logic [LINE_W-1:0]   wbuf_reg;
  logic [BURST_W-1:0]  wbeats [BEATS];
  logic                last_beat;
  logic [ADDR_W-1:0]   aligned_addr;
  logic                unused_offset;

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_wbeat
      assign wbeats[gi] = wbuf_reg[gi*BURST_W +: BURST_W];
    end
  endgenerate

  assign last_beat     = (beat_reg == CNT_W'(BEATS - 1));
  assign aligned_addr  = {address_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign unused_offset = ^address_i[OFFSET_W-1:0];

  // Gated by write_o so a stale buffer never shows on the bus outside a burst.
  assign burst_o = write_o ? wbeats[beat_reg] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      wbuf_reg  <= '0;
      line_o    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          beat_reg <= '0;
          if (write_i) begin
            wbuf_reg  <= line_i;
            address_o <= aligned_addr;
            write_o   <= 1'b1;
            state_reg <= WRITE;
          end else if (read_i) begin
            address_o <= aligned_addr;
            read_o    <= 1'b1;
            state_reg <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[BURST_W*beat_reg +: BURST_W] <= burst_i;
            if (last_beat) begin
              beat_reg  <= '0;
              read_o    <= 1'b0;
              resp_o    <= 1'b1;
              state_reg <= RESP;
            end else begin
              beat_reg <= beat_reg + 1'b1;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            if (last_beat) begin
              beat_reg  <= '0;
              write_o   <= 1'b0;
              resp_o    <= 1'b1;
              state_reg <= RESP;
            end else begin
              beat_reg <= beat_reg + 1'b1;
            end
          end
        end
        RESP: begin
          resp_o    <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic rd_done;
  logic wr_done;

  assign rd_done = (state_reg == READ)  && resp_i && last_beat;
  assign wr_done = (state_reg == WRITE) && resp_i && last_beat;

  // Saturating counters, bumped on the edge that enters RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else begin
      if (rd_done && (rd_count_o != '1)) rd_count_o <= rd_count_o + 32'd1;
      if (wr_done && (wr_count_o != '1)) wr_count_o <= wr_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed plus randomized bench for cacheline_adaptor with a line-level reference model.
module tb_cacheline_adaptor;
  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;
  localparam int BEATS    = LINE_W / BURST_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;
`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic [31:0]        rd_count_o;
  logic [31:0]        wr_count_o;
`endif

  cacheline_adaptor #(
    .LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
`ifdef CACHELINE_ADAPTOR_PERF_EN
    , .rd_count_o(rd_count_o), .wr_count_o(wr_count_o)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: last line returned to the cache and completed-transaction counts.
  logic [LINE_W-1:0] model_line = '0;
  longint            model_rd   = 0;
  longint            model_wr   = 0;

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & ~((ADDR_W'(1) << OFFSET_W) - 1);
  endfunction

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_read_o"},  read_o,  1'b0);
    check({tag, "_write_o"}, write_o, 1'b0);
    check({tag, "_resp_o"},  resp_o,  1'b0);
    check({tag, "_line_o"},  line_o,  model_line);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data,
                         input int min_stall, input int max_stall, input bit b2b);
    int cyc = 0;
    int stall;
    address_i = addr;
    read_i    = 1'b1;
    if (b2b) begin
      @(negedge clk);
      check("b2b_idle_read_o", read_o, 1'b0);
      check("b2b_idle_resp_o", resp_o, 1'b0);
    end
    @(negedge clk); cyc++;
    check("rd_read_o", read_o, 1'b1);
    check("rd_write_o", write_o, 1'b0);
    check("rd_address_o", address_o, align(addr));
    for (int k = 0; k < BEATS; k++) begin
      address_i = $urandom;
      stall = $urandom_range(max_stall, min_stall);
      repeat (stall) begin
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        @(negedge clk); cyc++;
        check("rd_stall_read_o", read_o, 1'b1);
        check("rd_stall_resp_o", resp_o, 1'b0);
      end
      resp_i  = 1'b1;
      burst_i = data[BURST_W*k +: BURST_W];
      @(negedge clk); cyc++;
    end
    resp_i  = 1'b0;
    read_i  = 1'b0;
    burst_i = {$urandom, $urandom};
    model_line = data;
    if (model_rd < 64'hFFFF_FFFF) model_rd++;
    check("rd_resp_o", resp_o, 1'b1);
    check("rd_read_o_drop", read_o, 1'b0);
    check("rd_line_o", line_o, model_line);
    // Accept edge plus one edge per beat, then resp_o is high in the RESP cycle.
    if (min_stall == 0 && max_stall == 0 && !b2b) check("rd_latency", cyc, BEATS + 1);
    @(negedge clk);
    check("rd_resp_single", resp_o, 1'b0);
    check("rd_line_hold", line_o, model_line);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data,
                          input int min_stall, input int max_stall, input bit also_read, input bit tail);
    int stall;
    address_i = addr;
    line_i    = data;
    write_i   = 1'b1;
    read_i    = also_read;
    @(negedge clk);
    check("wr_write_o", write_o, 1'b1);
    check("wr_read_o", read_o, 1'b0);
    check("wr_address_o", address_o, align(addr));
    for (int k = 0; k < BEATS; k++) begin
      line_i    = {8{$urandom}};
      address_i = $urandom;
      stall = $urandom_range(max_stall, min_stall);
      repeat (stall) begin
        check("wr_stall_burst_o", burst_o, data[BURST_W*k +: BURST_W]);
        check("wr_stall_write_o", write_o, 1'b1);
        check("wr_stall_read_o", read_o, 1'b0);
        resp_i = 1'b0;
        @(negedge clk);
      end
      check("wr_burst_o", burst_o, data[BURST_W*k +: BURST_W]);
      resp_i = 1'b1;
      @(negedge clk);
    end
    resp_i  = 1'b0;
    write_i = 1'b0;
    read_i  = 1'b0;
    if (model_wr < 64'hFFFF_FFFF) model_wr++;
    check("wr_resp_o", resp_o, 1'b1);
    check("wr_write_o_drop", write_o, 1'b0);
    check("wr_read_o_none", read_o, 1'b0);
    check("wr_line_o_untouched", line_o, model_line);
    if (tail) begin
      @(negedge clk);
      check("wr_resp_single", resp_o, 1'b0);
    end
  endtask

  initial begin
    logic [LINE_W-1:0] d;
    rst_n = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_address_o", address_o, '0);
    check("reset_burst_o", burst_o, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed read with consecutive beats.
    d = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_read(32'h0000_1234, d, 0, 0, 1'b0);
    check("rd_addr_const", address_o, 32'h0000_1220);

    // Write with beat k = 0xA0+k replicated, three stall cycles before each beat.
    for (int k = 0; k < BEATS; k++) d[BURST_W*k +: BURST_W] = {8{8'(8'hA0 + k)}};
    do_write(32'h0000_4567, d, 3, 3, 1'b0, 1'b1);

    // read_i and write_i together: write only, and no read burst afterwards.
    do_write($urandom, {8{$urandom}}, 0, 1, 1'b1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("after_both");
    end

    // Reset two beats into a read.
    address_i = 32'h0000_8000; read_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    resp_i = 1'b0; read_i = 1'b0; rst_n = 1'b0;
    #1;
    model_line = '0; model_rd = 0; model_wr = 0;
    check_idle_outputs("abort");
    check("abort_address_o", address_o, '0);
    check("abort_burst_o", burst_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("post_abort");
    end

    // Write-back then allocate, read issued during the write's RESP cycle.
    do_write($urandom, {8{$urandom}}, 0, 1, 1'b0, 1'b0);
    do_read($urandom, {8{$urandom}}, 0, 1, 1'b1);

    // Stray memory strobes while idle.
    repeat (3) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      @(negedge clk);
      check_idle_outputs("stray");
    end
    resp_i = 1'b0;
`ifdef CACHELINE_ADAPTOR_PERF_EN
    check("perf_rd", rd_count_o, 32'd1);
    check("perf_wr", wr_count_o, 32'd1);
`endif

    // Randomized mix of transactions.
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(1, 0) == 1)
        do_write($urandom, {8{$urandom}}, 0, 2, 1'($urandom_range(1, 0)), 1'b1);
      else
        do_read($urandom, {8{$urandom}}, 0, 2, 1'b0);
      repeat ($urandom_range(2, 0)) begin
        @(negedge clk);
        check_idle_outputs("rand_gap");
      end
    end
`ifdef CACHELINE_ADAPTOR_PERF_EN
    check("perf_rd_final", rd_count_o, 32'(model_rd));
    check("perf_wr_final", wr_count_o, 32'(model_wr));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
